// File: rtl/sequenced_decoder_pkg.sv
// Shared constants for the sequenced decoder: mode encodings seen on the mode port.
package sequenced_decoder_pkg;

   localparam logic [1:0] MODE_DIRECT    = 2'b00;
   localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
   localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
   localparam logic [1:0] MODE_HOLD      = 2'b11;

endpackage

// File: rtl/sequenced_decoder_onehot_decoder.sv
// Combinational index-to-one-hot converter; all-zero when disabled.
module onehot_decoder #(
   parameter int ADDR_W = 3
) (
   input  logic                   en_i,
   input  logic [ADDR_W-1:0]      addr_i,
   output logic [2**ADDR_W-1:0]   onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[addr_i] = 1'b1;
   end

endmodule

// File: rtl/sequenced_decoder.sv
// Address decoder with direct load, prescaled up/down scanning, hold and wrap pulse.
// Output is a registered one-hot of the next selected index.
module sequenced_decoder
   import sequenced_decoder_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int DIV_W  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_W-1:0]     address,
   input  logic [DIV_W-1:0]      div,
   output logic [2**ADDR_W-1:0]  out,
   output logic [ADDR_W-1:0]     cur_addr,
   output logic                  wrap
);

   localparam int N = 2**ADDR_W;

   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [DIV_W-1:0]  pre_q, pre_d;
   logic [1:0]        mode_q, mode_d;
   logic              wrap_q, wrap_d;
   logic [N-1:0]      out_q, out_d;
   logic              accept, mode_chg, scanning, step;

   assign in_ready = enable && (mode != MODE_HOLD);
   assign accept   = in_valid && in_ready;
   assign mode_chg = (mode != mode_q);
   assign scanning = (mode == MODE_SCAN_UP) || (mode == MODE_SCAN_DOWN);
   // >= rather than == so a div lowered below the running count steps at once
   assign step     = scanning && !mode_chg && (pre_q >= div);

   always_comb begin
      cur_d  = cur_q;
      pre_d  = pre_q;
      mode_d = mode_q;
      wrap_d = 1'b0;
      if (enable) begin
         mode_d = mode;
         if (accept) begin
            cur_d = address;
            pre_d = '0;
         end else if (mode_chg) begin
            pre_d = '0;
         end else if (step) begin
            pre_d = '0;
            if (mode == MODE_SCAN_UP) begin
               cur_d  = cur_q + ADDR_W'(1);
               wrap_d = &cur_q;
            end else begin
               cur_d  = cur_q - ADDR_W'(1);
               wrap_d = ~|cur_q;
            end
         end else if (scanning) begin
            pre_d = pre_q + DIV_W'(1);
         end
      end
   end

   onehot_decoder #(.ADDR_W(ADDR_W)) u_onehot (
      .en_i     (enable),
      .addr_i   (cur_d),
      .onehot_o (out_d)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_q  <= '0;
         pre_q  <= '0;
         mode_q <= MODE_DIRECT;
         wrap_q <= 1'b0;
         out_q  <= '0;
      end else begin
         cur_q  <= cur_d;
         pre_q  <= pre_d;
         mode_q <= mode_d;
         wrap_q <= wrap_d;
         out_q  <= out_d;
      end
   end

   assign out      = out_q;
   assign cur_addr = cur_q;
   assign wrap     = wrap_q;

endmodule

// File: tb/tb_sequenced_decoder.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares each cycle.
module tb_sequenced_decoder;

   localparam int AW = 3;
   localparam int DW = 4;
   localparam int N  = 8;
   localparam logic [1:0] DIRECT = 2'd0, UP = 2'd1, DOWN = 2'd2, HOLD = 2'd3;

   logic          clk = 1'b0, reset = 1'b1, enable = 1'b0, in_valid = 1'b0;
   logic [1:0]    mode = DIRECT;
   logic [AW-1:0] address = '0;
   logic [DW-1:0] div = '0;
   logic          in_ready, wrap;
   logic [N-1:0]  out;
   logic [AW-1:0] cur_addr;

   typedef struct {
      logic [N-1:0]  out;
      logic [AW-1:0] cur;
      logic          wrap;
   } exp_t;

   exp_t sb[$];
   int   tests = 0, fails = 0;

   // reference state: selected index, prescaler count, last seen mode
   int         m_idx = 0, m_cnt = 0;
   logic [1:0] m_mode = DIRECT;

   always #5 clk = ~clk;

   sequenced_decoder #(.ADDR_W(AW), .DIV_W(DW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .in_valid(in_valid), .in_ready(in_ready), .address(address),
      .div(div), .out(out), .cur_addr(cur_addr), .wrap(wrap)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected result of the coming rising edge, from the current inputs.
   task automatic model_edge();
      exp_t e;
      int   nidx, ncnt;
      bit   nwrap;
      nidx = m_idx; ncnt = m_cnt; nwrap = 0;
      if (reset) begin
         m_idx = 0; m_cnt = 0; m_mode = DIRECT;
         e.out = '0; e.cur = '0; e.wrap = 1'b0;
      end else if (!enable) begin
         e.out = '0; e.cur = AW'(m_idx); e.wrap = 1'b0;
      end else begin
         if (in_valid && mode != HOLD) begin
            nidx = int'(address); ncnt = 0;
         end else if (mode != m_mode) begin
            ncnt = 0;
         end else if (mode == UP || mode == DOWN) begin
            if (m_cnt >= int'(div)) begin
               ncnt = 0;
               if (mode == UP) begin
                  nidx = (m_idx + 1) % N; nwrap = (m_idx == N - 1);
               end else begin
                  nidx = (m_idx + N - 1) % N; nwrap = (m_idx == 0);
               end
            end else begin
               ncnt = m_cnt + 1;
            end
         end
         m_mode = mode; m_idx = nidx; m_cnt = ncnt;
         e.out = N'(1) << nidx; e.cur = AW'(nidx); e.wrap = nwrap;
      end
      sb.push_back(e);
   endtask

   task automatic step(input logic r, input logic en, input logic [1:0] md, input logic v,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      reset = r; enable = en; mode = md; in_valid = v; address = a; div = d;
      #1 chk("in_ready", 32'(in_ready), 32'(en && (md != HOLD)));
      model_edge();
   endtask

   task automatic expect_now(input string name, input logic [N-1:0] o,
                             input logic [AW-1:0] c, input logic w);
      @(posedge clk);
      #2;
      chk({name, "_out"}, 32'(out), 32'(o));
      chk({name, "_cur"}, 32'(cur_addr), 32'(c));
      chk({name, "_wrap"}, 32'(wrap), 32'(w));
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_out", 32'(out), 32'(e.out));
            chk("sb_cur", 32'(cur_addr), 32'(e.cur));
            chk("sb_wrap", 32'(wrap), 32'(e.wrap));
            chk("onehot0", 32'($onehot0(out)), 32'd1);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      #1;
      chk("rst_out", 32'(out), 32'd0);
      chk("rst_cur", 32'(cur_addr), 32'd0);
      chk("rst_wrap", 32'(wrap), 32'd0);
      step(1, 1, UP, 0, 0, 0);
      step(1, 0, DIRECT, 0, 0, 0);

      // direct decode of 5
      step(0, 1, DIRECT, 1, 5, 0);
      expect_now("direct5", 8'b0010_0000, 3'd5, 1'b0);

      // scan up, div=2, from 6 through wrap
      step(0, 1, DIRECT, 1, 6, 2);
      repeat (4) step(0, 1, UP, 0, 0, 2);
      expect_now("up_to7", 8'h80, 3'd7, 1'b0);
      repeat (3) step(0, 1, UP, 0, 0, 2);
      expect_now("up_wrap", 8'h01, 3'd0, 1'b1);

      // scan down, div=0, from 1 through wrap
      step(0, 1, DIRECT, 1, 1, 0);
      repeat (3) step(0, 1, DOWN, 0, 0, 0);
      expect_now("down_wrap", 8'h80, 3'd7, 1'b1);
      step(0, 1, DOWN, 0, 0, 0);
      expect_now("down_6", 8'h40, 3'd6, 1'b0);

      // acceptance coinciding with a wrapping step
      step(0, 1, UP, 0, 0, 1);
      step(0, 1, UP, 1, 7, 1);
      step(0, 1, UP, 0, 0, 1);
      step(0, 1, UP, 1, 3, 1);
      expect_now("coincide", 8'h08, 3'd3, 1'b0);
      step(0, 1, UP, 0, 0, 1);
      expect_now("pre_cleared", 8'h08, 3'd3, 1'b0);

      // disable for 4 cycles mid-scan
      step(0, 1, UP, 1, 2, 0);
      repeat (2) step(0, 1, UP, 0, 0, 0);
      repeat (4) step(0, 0, UP, 0, 0, 0);
      expect_now("disabled", 8'h00, 3'd4, 1'b0);
      step(0, 1, UP, 0, 0, 0);
      expect_now("reenable", 8'h20, 3'd5, 1'b0);

      // asynchronous reset mid-scan
      repeat (2) step(0, 1, UP, 0, 0, 0);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_out", 32'(out), 32'd0);
      chk("async_cur", 32'(cur_addr), 32'd0);
      chk("async_wrap", 32'(wrap), 32'd0);
      m_idx = 0; m_cnt = 0; m_mode = DIRECT;
      step(1, 1, UP, 0, 0, 0);
      step(0, 1, UP, 0, 0, 0);
      expect_now("post_rst", 8'h01, 3'd0, 1'b0);

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0, 3'($urandom), 4'($urandom_range(0, 3)));

      step(0, 1, HOLD, 1, 0, 0);
      @(posedge clk);
      #2 chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sequenced_decoder.md
SEQUENCED_DECODER -- requirements
Module: sequenced_decoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 3: address width; output width is 2**ADDR_W.
REQ-002 SHALL have parameter DIV_W, default 4: scan prescaler width.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: 0 forces out to all-zero and freezes all state.
REQ-006 SHALL have port mode, input, 2: 00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
REQ-007 SHALL have port in_valid, input, 1: address offer.
REQ-008 SHALL have port in_ready, output, 1: address acceptance.
REQ-009 SHALL have port address, input, ADDR_W: address to decode or scan start point.
REQ-010 SHALL have port div, input, DIV_W: scan step period minus one.
REQ-011 SHALL have port out, output, 2**ADDR_W: registered one-hot decode.
REQ-012 SHALL have port cur_addr, output, ADDR_W: current selected index.
REQ-013 SHALL have port wrap, output, 1: one-cycle pulse on scan wrap-around.

Function
REQ-014 SHALL drive in_ready = enable AND (mode != HOLD), combinationally.
REQ-015 SHALL accept an address on any cycle with in_valid AND in_ready, loading cur_addr on that edge.
REQ-016 SHALL register out <= enable ? onehot(next cur_addr) : 0, giving 1-cycle latency from acceptance to out.
REQ-017 SHALL, in DIRECT, change cur_addr only on acceptance.
REQ-018 SHALL, in SCAN_UP/SCAN_DOWN, count prescaler 0..div, then step cur_addr by +1/-1 and clear the prescaler; div=0 steps every cycle.
REQ-019 SHALL wrap modulo 2**ADDR_W: all-ones+1 -> 0 and 0-1 -> all-ones, asserting wrap for exactly the following cycle.
REQ-020 SHALL, when acceptance and a scan step coincide, load the accepted address, clear the prescaler, and assert no wrap.
REQ-021 SHALL, in HOLD, freeze cur_addr and the prescaler; out keeps decoding cur_addr.
REQ-022 SHALL clear the prescaler on the cycle after any mode change; cur_addr is unchanged by a mode change.
REQ-023 SHALL, when enable=0, hold cur_addr and the prescaler, deassert wrap, and clear out one cycle later; re-enable restores onehot(cur_addr) one cycle later.
REQ-024 SHALL keep out either all-zero or exactly one-hot at all times.
REQ-025 SHALL sample div only at prescaler comparison; a div decrease below the current prescaler count steps on the next cycle.

Reset
REQ-026 SHALL, while reset=1, immediately force cur_addr=0, prescaler=0, out=0, wrap=0, and the stored mode=DIRECT.
REQ-027 SHALL, on reset mid-scan, abandon the scan; the first post-reset edge with enable=1 gives out=onehot(0), or onehot(address) if accepted.

Structure
REQ-028 SHALL place the mode encodings (DIRECT, SCAN_UP, SCAN_DOWN, HOLD) as named constants in the shared decoder package.
REQ-029 SHALL implement the one-hot conversion as sub-module onehot_decoder (parameter ADDR_W, combinational, enable input), instantiated once.
REQ-030 SHALL implement the prescaler and the cur_addr register in the top module, with no other sub-modules.

Verification
REQ-031 SHALL cover DIRECT with ADDR_W=3: accept address=5 -> next cycle out=8'b0010_0000, cur_addr=5.
REQ-032 SHALL cover SCAN_UP with div=2 from cur_addr=6 -> steps every 3 cycles to 7, then 0, with wrap high one cycle after 7->0.
REQ-033 SHALL cover SCAN_DOWN with div=0 from 1 -> 0, 7, 6 on consecutive cycles, with wrap after 0->7.
REQ-034 SHALL cover acceptance of address=3 coinciding with a scan step -> cur_addr=3, prescaler=0, wrap=0.
REQ-035 SHALL cover enable=0 for 4 cycles during SCAN_UP -> out=0, cur_addr frozen; re-enable resumes from the same index.
REQ-036 SHALL cover reset asserted asynchronously mid-scan -> out=0, cur_addr=0 before the next clk edge; in_ready=enable after release.
